// File: rtl/mem_responder.sv
// Word-addressed memory responder: single-cycle writes, fixed-latency reads with a one-cycle read_valid pulse.
// Misaligned or out-of-range requests raise addr_error; faulting writes are dropped and faulting reads return zero.
module mem_responder #(
  parameter int DEPTH_WORDS  = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        busy,
  output logic        addr_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_err;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [29:0]       word_idx;
  logic [IDX_W-1:0]  req_idx;
  logic              req_err;
  logic              wr_en;

  // Full 30-bit compare: addresses past the array top must fault, never alias.
  assign word_idx = address[31:2];
  assign req_idx  = word_idx[IDX_W-1:0];
  assign req_err  = (address[1:0] != 2'b00) || (word_idx >= 30'(DEPTH_WORDS));
  assign wr_en    = !reset && (state == IDLE) && mem_req && memory_write && !req_err;

  function automatic logic [31:0] fetch(input logic [IDX_W-1:0] idx, input logic err);
    fetch = err ? 32'h0 : mem[idx];
  endfunction

  // Array has no reset: contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[req_idx] <= write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      rd_idx     <= '0;
      rd_err     <= 1'b0;
      read_data  <= 32'h0;
      read_valid <= 1'b0;
      busy       <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_error <= req_err;
            if (!memory_write) begin
              rd_idx  <= req_idx;
              rd_err  <= req_err;
              lat_cnt <= 4'(READ_LATENCY - 1);
              busy    <= 1'b1;
              if (READ_LATENCY == 1) begin
                state      <= RESP;
                read_data  <= fetch(req_idx, req_err);
                read_valid <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state      <= RESP;
            read_data  <= fetch(rd_idx, rd_err);
            read_valid <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: per-cycle vector table on a READ_LATENCY=2 instance,
// plus a hand-written sequence on a READ_LATENCY=1 instance.
module tb_mem_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, mem_req, memory_write;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        read_valid, busy, addr_error;

  logic        reset1, mem_req1, memory_write1;
  logic [31:0] address1, write_data1;
  logic [31:0] read_data1;
  logic        read_valid1, busy1, addr_error1;

  mem_responder #(.DEPTH_WORDS(64), .READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .memory_write(memory_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .read_valid(read_valid), .busy(busy), .addr_error(addr_error)
  );

  mem_responder #(.DEPTH_WORDS(64), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset1), .mem_req(mem_req1), .memory_write(memory_write1),
    .address(address1), .write_data(write_data1), .read_data(read_data1),
    .read_valid(read_valid1), .busy(busy1), .addr_error(addr_error1)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_rv;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  task automatic v(input logic rst, input logic req, input logic wr,
                   input logic [31:0] addr, input logic [31:0] wdat,
                   input logic [31:0] rd, input logic rv, input logic bsy, input logic err);
    vec_t e;
    e.rst = rst; e.req = req; e.wr = wr; e.addr = addr; e.wdat = wdat;
    e.exp_rd = rd; e.exp_rv = rv; e.exp_busy = bsy; e.exp_err = err;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdat);
    mem_req1 = req; memory_write1 = wr; address1 = addr; write_data1 = wdat;
  endtask

  initial begin
    reset = 1'b1; mem_req = 1'b0; memory_write = 1'b0; address = '0; write_data = '0;
    reset1 = 1'b1; mem_req1 = 1'b0; memory_write1 = 1'b0; address1 = '0; write_data1 = '0;
    repeat (2) @(posedge clock);
    #1;
    reset1 = 1'b0;

    //  rst req wr  addr      wdat          exp_rd        rv bsy err
    v(1, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0);  // reset state
    v(0, 1, 1, 32'h00, 32'hA5A5A5A5, 32'h0,        0, 0, 0);
    v(0, 1, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    v(0, 1, 0, 32'h10, 32'h0,        32'h0,        0, 1, 0);  // read accept -> WAIT
    v(0, 0, 0, 32'h00, 32'h0,        32'hDEADBEEF, 1, 1, 0);  // RESP
    v(0, 0, 1, 32'h10, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 0, 0);  // no req: no write
    v(0, 1, 1, 32'h04, 32'h1,        32'hDEADBEEF, 0, 0, 0);
    v(0, 1, 1, 32'h04, 32'h2,        32'hDEADBEEF, 0, 0, 0);
    v(0, 1, 0, 32'h04, 32'h0,        32'hDEADBEEF, 0, 1, 0);  // read after write
    v(0, 0, 0, 32'h00, 32'h0,        32'h2,        1, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'h2,        0, 0, 0);
    v(0, 1, 0, 32'h10, 32'h0,        32'h2,        0, 1, 0);  // req held high
    v(0, 1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 1, 1, 0);
    v(0, 1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0);  // ignored in RESP
    v(0, 1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 0);  // accepted 3 cycles later
    v(0, 0, 0, 32'h00, 32'h0,        32'hDEADBEEF, 1, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    v(0, 1, 1, 32'h102, 32'h11111111, 32'hDEADBEEF, 0, 0, 1); // misaligned write
    v(0, 1, 1, 32'h100, 32'h22222222, 32'hDEADBEEF, 0, 0, 1); // out-of-range write
    v(0, 0, 0, 32'h00, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    v(0, 1, 0, 32'h00, 32'h0,        32'hDEADBEEF, 0, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'hA5A5A5A5, 1, 1, 0);  // word 0 not aliased
    v(0, 0, 0, 32'h00, 32'h0,        32'hA5A5A5A5, 0, 0, 0);
    v(0, 1, 0, 32'h100, 32'h0,       32'hA5A5A5A5, 0, 1, 1);  // faulting read
    v(0, 0, 0, 32'h00, 32'h0,        32'h0,        1, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0);
    v(0, 1, 0, 32'h04, 32'h0,        32'h0,        0, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'h2,        1, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'h2,        0, 0, 0);
    v(0, 1, 1, 32'h08, 32'h12345678, 32'h2,        0, 0, 0);
    v(0, 1, 0, 32'h08, 32'h0,        32'h2,        0, 1, 0);  // read in flight
    v(1, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0);  // reset in WAIT
    v(0, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0);  // no stray read_valid
    v(0, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0);
    v(0, 1, 0, 32'h08, 32'h0,        32'h0,        0, 1, 0);
    v(0, 0, 0, 32'h00, 32'h0,        32'h12345678, 1, 1, 0);  // array survived reset
    v(0, 0, 0, 32'h00, 32'h0,        32'h12345678, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; mem_req = vecs[i].req; memory_write = vecs[i].wr;
      address = vecs[i].addr; write_data = vecs[i].wdat;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d read_data", i),  read_data,          vecs[i].exp_rd);
      chk($sformatf("v%0d read_valid", i), {31'b0, read_valid}, {31'b0, vecs[i].exp_rv});
      chk($sformatf("v%0d busy", i),       {31'b0, busy},       {31'b0, vecs[i].exp_busy});
      chk($sformatf("v%0d addr_error", i), {31'b0, addr_error}, {31'b0, vecs[i].exp_err});
    end
    reset = 1'b0; mem_req = 1'b0;

    // READ_LATENCY=1 instance
    drive1(1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clock); #1;
    chk("lat1 write busy", {31'b0, busy1}, 32'h0);
    chk("lat1 write rv",   {31'b0, read_valid1}, 32'h0);
    drive1(1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge clock); #1;
    chk("lat1 read rv",    {31'b0, read_valid1}, 32'h1);
    chk("lat1 read data",  read_data1, 32'hCAFEF00D);
    chk("lat1 read busy",  {31'b0, busy1}, 32'h1);
    @(posedge clock); #1;
    chk("lat1 resp ignore rv",   {31'b0, read_valid1}, 32'h0);
    chk("lat1 resp ignore busy", {31'b0, busy1}, 32'h0);
    @(posedge clock); #1;
    chk("lat1 reissue rv", {31'b0, read_valid1}, 32'h1);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    chk("lat1 idle rv", {31'b0, read_valid1}, 32'h0);
    drive1(1'b1, 1'b0, 32'h21, 32'h0);
    @(posedge clock); #1;
    chk("lat1 misaligned rv",   {31'b0, read_valid1}, 32'h1);
    chk("lat1 misaligned data", read_data1, 32'h0);
    chk("lat1 misaligned err",  {31'b0, addr_error1}, 32'h1);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    chk("lat1 err pulse end", {31'b0, addr_error1}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
